// File: rtl/simon_pkg.sv
// -----------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon Says phase sequencer: FSM state encoding,
// 2-bit debug phase codes, round counter width and a state-to-phase helper.
// -----------------------------------------------------------------------------
package simon_pkg;

    localparam int ROUND_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_DISP  = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_NEXT  = 3'd5,
        S_WIN   = 3'd6,
        S_LOSE  = 3'd7
    } state_t;

    localparam logic [1:0] PHASE_IDLE  = 2'b00;
    localparam logic [1:0] PHASE_DISP  = 2'b01;
    localparam logic [1:0] PHASE_WAIT  = 2'b10;
    localparam logic [1:0] PHASE_CHECK = 2'b11;

    // Debug phase code; idle, generate, round advance and end states all read 00.
    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            S_DISP:  phase_of = PHASE_DISP;
            S_WAIT:  phase_of = PHASE_WAIT;
            S_CHECK: phase_of = PHASE_CHECK;
            default: phase_of = PHASE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/simon_timeout_timer.sv
// -----------------------------------------------------------------------------
// simon_timeout_timer
// Player-input inactivity counter used while the game waits for button presses.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_clear     - force count to 0 (held while not waiting for the player)
//   i_reload    - any colour button pressed: restart the count from 0
//   i_enable    - count one per cycle
//   o_tc        - terminal count: count == TIMEOUT_CYCLES-1 while enabled
// -----------------------------------------------------------------------------
module simon_timeout_timer #(
    parameter int              TO_W           = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_reload,
    input  logic i_enable,
    output logic o_tc
);

    localparam logic [TO_W-1:0] TC_VAL = TIMEOUT_CYCLES - TO_W'(1);

    logic [TO_W-1:0] r_cnt;
    logic            w_at_tc;

    assign w_at_tc = (r_cnt == TC_VAL);
    assign o_tc    = i_enable & w_at_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || i_reload) begin
            r_cnt <= '0;
        end else if (i_enable && !w_at_tc) begin
            // Holding at the terminal value keeps the flag stable instead of wrapping.
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/simon_game_ctrl.sv
// -----------------------------------------------------------------------------
// simon_game_ctrl
// Central phase sequencer for the Simon Says datapath. One FSM drives the
// generate / display / wait / check stage enables, owns the round counter,
// per-round stage resets, the player-input timeout and the win/lose status.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   start                   - start button level (rising edge starts a game)
//   abort                   - synchronous soft reset, active high
//   btn_any                 - any colour button; restarts the timeout
//   gen_done/disp_done/wait_done - stage completion levels
//   check_pass/check_fail   - check stage result
//   gen_en/disp_en/wait_en/check_en - registered stage enables
//   stage_rst               - one-cycle reset pulse to display/wait/check
//   round                   - current round; sequence length = round+1
//   phase                   - debug code 00 idle/gen, 01 disp, 10 wait, 11 check
//   game_win/game_lose/timed_out - sticky status flags
// All outputs are registered from the next-state decode so they line up with
// the state register.
// -----------------------------------------------------------------------------
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int              MAX_ROUNDS     = 16,
    parameter int              TO_W           = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               btn_any,
    input  logic               gen_done,
    input  logic               disp_done,
    input  logic               wait_done,
    input  logic               check_pass,
    input  logic               check_fail,
    output logic               gen_en,
    output logic               disp_en,
    output logic               wait_en,
    output logic               check_en,
    output logic               stage_rst,
    output logic [ROUND_W-1:0] round,
    output logic [1:0]         phase,
    output logic               game_win,
    output logic               game_lose,
    output logic               timed_out
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS - 1);

    state_t             r_state, w_state_nxt;
    logic [ROUND_W-1:0] r_round, w_round_nxt;
    logic               r_win, w_win_nxt;
    logic               r_lose, w_lose_nxt;
    logic               r_to, w_to_nxt;
    logic               w_srst_nxt;
    logic               r_start_d;
    logic               r_start_armed;
    logic               w_start_rise;
    logic               w_tc;
    logic               w_timeout;

    // r_start_armed blocks a start held high through reset release from
    // looking like a fresh press: r_start_d holds no real sample until one
    // clock after reset.
    assign w_start_rise = start & ~r_start_d & r_start_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d     <= 1'b0;
            r_start_armed <= 1'b0;
        end else begin
            r_start_d     <= start;
            r_start_armed <= 1'b1;
        end
    end

    simon_timeout_timer #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != S_WAIT),
        .i_reload (btn_any),
        .i_enable (r_state == S_WAIT),
        .o_tc     (w_tc)
    );

    assign w_timeout = w_tc & ~btn_any;

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_win_nxt   = r_win;
        w_lose_nxt  = r_lose;
        w_to_nxt    = r_to;
        w_srst_nxt  = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = '0;
            w_win_nxt   = 1'b0;
            w_lose_nxt  = 1'b0;
            w_to_nxt    = 1'b0;
            w_srst_nxt  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_rise) w_state_nxt = S_GEN;
                S_GEN:   if (gen_done)     w_state_nxt = S_DISP;
                S_DISP:  if (disp_done)    w_state_nxt = S_WAIT;
                S_WAIT: begin
                    // A completed capture beats a timeout landing on the same cycle.
                    if (wait_done) begin
                        w_state_nxt = S_CHECK;
                    end else if (w_timeout) begin
                        w_state_nxt = S_LOSE;
                        w_lose_nxt  = 1'b1;
                        w_to_nxt    = 1'b1;
                    end
                end
                S_CHECK: begin
                    if (check_fail) begin
                        w_state_nxt = S_LOSE;
                        w_lose_nxt  = 1'b1;
                    end else if (check_pass) begin
                        if (r_round == LAST_ROUND) begin
                            w_state_nxt = S_WIN;
                            w_win_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = S_NEXT;
                            w_srst_nxt  = 1'b1;
                            w_round_nxt = (r_round == '1) ? r_round : r_round + ROUND_W'(1);
                        end
                    end
                end
                S_NEXT:  w_state_nxt = S_DISP;
                S_WIN, S_LOSE: begin
                    if (w_start_rise) begin
                        w_state_nxt = S_GEN;
                        w_round_nxt = '0;
                        w_win_nxt   = 1'b0;
                        w_lose_nxt  = 1'b0;
                        w_to_nxt    = 1'b0;
                        w_srst_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_round   <= '0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
            r_to      <= 1'b0;
            gen_en    <= 1'b0;
            disp_en   <= 1'b0;
            wait_en   <= 1'b0;
            check_en  <= 1'b0;
            stage_rst <= 1'b0;
            phase     <= PHASE_IDLE;
        end else begin
            r_state   <= w_state_nxt;
            r_round   <= w_round_nxt;
            r_win     <= w_win_nxt;
            r_lose    <= w_lose_nxt;
            r_to      <= w_to_nxt;
            gen_en    <= (w_state_nxt == S_GEN);
            disp_en   <= (w_state_nxt == S_DISP);
            wait_en   <= (w_state_nxt == S_WAIT);
            check_en  <= (w_state_nxt == S_CHECK);
            stage_rst <= w_srst_nxt;
            phase     <= phase_of(w_state_nxt);
        end
    end

    assign round     = r_round;
    assign game_win  = r_win;
    assign game_lose = r_lose;
    assign timed_out = r_to;

endmodule

// File: doc/simon_game_ctrl.md
Name: simon_game_ctrl

Overview:
- Central phase sequencer for the Simon Says datapath.
- Replaces the chained complete/enable wiring between the generate (IDLE/LFSR→MEM), display, wait and check stages with one explicit FSM.
- Owns the round counter (sequence length), per-round sub-block resets, the player-input timeout, and the win/lose status and 2-bit debug phase code.
- Sits at top level between the game inputs (start/reset buttons) and the stage blocks.

Parameters:
- MAX_ROUNDS, 16, number of rounds to win; 32-bit sequence memory / 2 bits per colour; legal range 1..16.
- TIMEOUT_CYCLES, 24'd5_000_000, idle cycles allowed in WAIT before loss; minimum 2.
- TO_W, 24, width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start button level; rising edge detected internally
- abort  in  1  synchronous soft reset (game reset button); active high
- btn_any  in  1  OR of the four colour buttons; restarts the timeout
- gen_done  in  1  generate stage complete (level)
- disp_done  in  1  display stage complete (level)
- wait_done  in  1  wait stage captured round+1 colours (level)
- check_pass  in  1  check result: sequence matched
- check_fail  in  1  check result: mismatch
- gen_en  out  1  enable, generate stage
- disp_en  out  1  enable, display stage
- wait_en  out  1  enable, wait stage
- check_en  out  1  enable, check stage
- stage_rst  out  1  one-cycle reset pulse to display/wait/check stages
- round  out  4  current round index; sequence length = round+1
- phase  out  2  debug code: 00 idle/gen, 01 display, 10 wait, 11 check
- game_win  out  1  sticky win flag
- game_lose  out  1  sticky lose flag
- timed_out  out  1  sticky; set when loss was caused by timeout

Behaviour:
- rst_n low (async): state=S_IDLE, round=0, all enables=0, stage_rst=0, phase=00, game_win/game_lose/timed_out=0, timeout counter=0, start edge register=0.
- All outputs are registered; an enable asserts the cycle after the state is entered.
- States and transitions:
  - S_IDLE → S_GEN on start rising edge (start=1 while the previous sample was 0).
  - S_GEN: gen_en=1; → S_DISP when gen_done=1.
  - S_DISP: disp_en=1; → S_WAIT when disp_done=1; timeout counter cleared on entry.
  - S_WAIT: wait_en=1; → S_CHECK when wait_done=1.
    - Timeout counter increments each cycle; btn_any=1 reloads it to 0.
    - Counter reaching TIMEOUT_CYCLES-1 with btn_any=0 → S_LOSE and set timed_out.
    - wait_done and timeout in the same cycle: wait_done wins.
  - S_CHECK: check_en=1.
    - check_fail=1 → S_LOSE; if check_pass is also high, fail wins.
    - check_pass=1 and round==MAX_ROUNDS-1 → S_WIN.
    - check_pass=1 otherwise → S_NEXT.
  - S_NEXT (1 cycle): stage_rst=1, round<=round+1, all enables 0; → S_DISP. Sequence memory is not regenerated.
  - S_WIN / S_LOSE: set the respective flag; all enables 0.
    - Start rising edge → round=0, clear win/lose/timed_out, pulse stage_rst, → S_GEN.
- Done/pass/fail inputs are ignored outside their own state.
- round never wraps: saturating increment; MAX_ROUNDS=16 wins at round=15.
- phase: S_IDLE/S_GEN/S_NEXT/S_WIN/S_LOSE=00, S_DISP=01, S_WAIT=10, S_CHECK=11.
- abort=1 (synchronous, highest priority after rst_n): next cycle state=S_IDLE, round=0, flags cleared, enables 0, stage_rst pulsed once.
- start held high across a game does not retrigger; a new rising edge is required.

Decomposition:
- Shared package simon_pkg:
  - state enum (S_IDLE, S_GEN, S_DISP, S_WAIT, S_CHECK, S_NEXT, S_WIN, S_LOSE);
  - PHASE_* 2-bit constants;
  - ROUND_W=4.
- One sub-module: simon_timeout_timer (clear, reload, enable, terminal-count flag; parameter TIMEOUT_CYCLES).
- FSM and round counter stay in simon_game_ctrl.

Test Plan:
- Reset/idle: rst_n low then high → all outputs 0 and phase=00; start held at 1 from reset release → no transition until start goes 0→1.
- Full win (MAX_ROUNDS=3, TIMEOUT_CYCLES=20): start edge, then gen_done, then 3× (disp_done, wait_done, check_pass) → round goes 0,1,2; stage_rst pulses exactly twice; game_win=1 after the third pass; phase trace 00,01,10,11,00,…
- Mismatch: round 1, check_pass=1 and check_fail=1 in the same cycle → game_lose=1, timed_out=0, round stays 1.
- Timeout (TIMEOUT_CYCLES=20): enter WAIT, btn_any pulse at cycle 10, then idle → game_lose and timed_out both 1 exactly 20 cycles after the pulse; wait_done landing on the terminal cycle → S_CHECK, no loss.
- Abort mid-DISPLAY at round 2 → next cycle state=S_IDLE, round=0, stage_rst=1 for one cycle, disp_en=0.
- Restart after loss: start 0→1 in S_LOSE → flags clear, round=0, gen_en=1 within 2 cycles.
